mem_stage: RTL and testbench

- MEM pipeline stage, directly downstream of EX. It consumes the EX/MEM pipeline registers and drives the data-memory bus through a req/ack handshake.
- It stalls the pipeline while an access is outstanding and resolves branch/jump redirects.
- It produces the MEM/WB registers that feed writeback and the WB forwarding path.

---
 rtl/mem_stage.sv | 198 +++++++++++++++++++
 tb/tb_mem_stage.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses over a req/ack bus, stalls
// upstream while an access is outstanding and produces the MEM/WB registers.
module mem_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] EXMEM_pc_branch_i,
    input  logic [31:0] EXMEM_alu_i,
    input  logic        EXMEM_alu_do_branch_i,
    input  logic [31:0] EXMEM_b_i,
    input  logic [4:0]  EXMEM_reg_write_address_i,
    input  logic        EXMEM_ctrl_branch_i,
    input  logic [1:0]  EXMEM_ctrl_mem_read_i,
    input  logic [1:0]  EXMEM_ctrl_mem_write_i,
    input  logic        EXMEM_ctrl_reg_write_i,
    input  logic        EXMEM_ctrl_mem_to_reg_i,
    output logic        MEM_pc_src_o,
    output logic [31:0] MEM_pc_branch_o,
    output logic        MEM_stall_o,
    output logic        MEM_bus_err_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic [31:0] MEMWB_reg_write_data_o,
    output logic [4:0]  MEMWB_reg_write_address_o,
    output logic        MEMWB_ctrl_reg_write_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        abort_q;

    logic        is_store;
    logic [1:0]  sz;
    logic [1:0]  ld_sz;
    logic        acc;
    logic        misal;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [15:0] ld_half;
    logic [7:0]  ld_byte;
    logic [31:0] ld_ext;
    logic        issue;
    logic        misal_err;
    logic        ack_hit;
    logic        tmo;

    assign MEM_pc_src_o    = EXMEM_ctrl_branch_i & EXMEM_alu_do_branch_i;
    assign MEM_pc_branch_o = EXMEM_pc_branch_i;

    // A nonzero store size overrides any load size on the same instruction.
    assign is_store = |EXMEM_ctrl_mem_write_i;
    assign sz       = is_store ? EXMEM_ctrl_mem_write_i : EXMEM_ctrl_mem_read_i;
    assign ld_sz    = is_store ? 2'd0 : EXMEM_ctrl_mem_read_i;
    assign acc      = |sz;
    assign misal    = ((sz == 2'd1) && (EXMEM_alu_i[1:0] != 2'b00)) ||
                      ((sz == 2'd2) && EXMEM_alu_i[0]);

    always_comb begin
        be_c    = '0;
        wdata_c = EXMEM_b_i;
        case (sz)
            2'd1: be_c = '1;
            2'd2: begin
                be_c    = EXMEM_alu_i[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{EXMEM_b_i[15:0]}};
            end
            2'd3: begin
                be_c    = 4'b0001 << EXMEM_alu_i[1:0];
                wdata_c = {4{EXMEM_b_i[7:0]}};
            end
            default: be_c = '0;
        endcase
    end

    always_comb begin
        ld_half = EXMEM_alu_i[1] ? rdata_q[31:16] : rdata_q[15:0];
        ld_byte = rdata_q[{EXMEM_alu_i[1:0], 3'b000} +: 8];
        ld_ext  = rdata_q;
        case (ld_sz)
            2'd2:    ld_ext = {{16{ld_half[15]}}, ld_half};
            2'd3:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            default: ld_ext = rdata_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        MEM_stall_o = 1'b0;
        issue       = 1'b0;
        misal_err   = 1'b0;
        ack_hit     = 1'b0;
        tmo         = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc && misal) begin
                    misal_err = 1'b1;
                end else if (acc) begin
                    issue       = 1'b1;
                    MEM_stall_o = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                MEM_stall_o = 1'b1;
                // An ack arriving on the last allowed cycle still completes normally.
                if (dmem_ack_i) begin
                    ack_hit = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == TMO_LAST) begin
                    tmo     = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q                     <= '0;
            rdata_q                   <= '0;
            abort_q                   <= 1'b0;
            dmem_req_o                <= 1'b0;
            dmem_we_o                 <= 1'b0;
            dmem_addr_o               <= '0;
            dmem_be_o                 <= '0;
            dmem_wdata_o              <= '0;
            MEMWB_reg_write_data_o    <= '0;
            MEMWB_reg_write_address_o <= '0;
            MEMWB_ctrl_reg_write_o    <= 1'b0;
            MEM_bus_err_o             <= 1'b0;
        end else begin
            MEM_bus_err_o <= misal_err | tmo;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        dmem_req_o             <= 1'b1;
                        dmem_we_o              <= is_store;
                        dmem_addr_o            <= {EXMEM_alu_i[31:2], 2'b00};
                        dmem_be_o              <= be_c;
                        dmem_wdata_o           <= wdata_c;
                        abort_q                <= 1'b0;
                        MEMWB_ctrl_reg_write_o <= 1'b0;
                    end else if (misal_err) begin
                        MEMWB_ctrl_reg_write_o <= 1'b0;
                    end else begin
                        MEMWB_reg_write_data_o    <= EXMEM_alu_i;
                        MEMWB_reg_write_address_o <= EXMEM_reg_write_address_i;
                        MEMWB_ctrl_reg_write_o    <= EXMEM_ctrl_reg_write_i;
                    end
                end
                BUSY: begin
                    cnt_q                  <= cnt_q + 8'd1;
                    MEMWB_ctrl_reg_write_o <= 1'b0;
                    if (ack_hit) begin
                        rdata_q    <= dmem_rdata_i;
                        dmem_req_o <= 1'b0;
                    end else if (tmo) begin
                        dmem_req_o <= 1'b0;
                        abort_q    <= 1'b1;
                    end
                end
                DONE: begin
                    cnt_q                     <= '0;
                    MEMWB_reg_write_data_o    <= EXMEM_ctrl_mem_to_reg_i ? ld_ext : EXMEM_alu_i;
                    MEMWB_reg_write_address_o <= EXMEM_reg_write_address_i;
                    MEMWB_ctrl_reg_write_o    <= EXMEM_ctrl_reg_write_i & ~abort_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of single-instruction vectors with a scoreboard
// for bus requests and writebacks, plus hand-written reset/branch sequences.
module tb_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] EXMEM_pc_branch_i;
    logic [31:0] EXMEM_alu_i;
    logic        EXMEM_alu_do_branch_i;
    logic [31:0] EXMEM_b_i;
    logic [4:0]  EXMEM_reg_write_address_i;
    logic        EXMEM_ctrl_branch_i;
    logic [1:0]  EXMEM_ctrl_mem_read_i;
    logic [1:0]  EXMEM_ctrl_mem_write_i;
    logic        EXMEM_ctrl_reg_write_i;
    logic        EXMEM_ctrl_mem_to_reg_i;
    logic        MEM_pc_src_o;
    logic [31:0] MEM_pc_branch_o;
    logic        MEM_stall_o;
    logic        MEM_bus_err_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;
    logic [31:0] MEMWB_reg_write_data_o;
    logic [4:0]  MEMWB_reg_write_address_o;
    logic        MEMWB_ctrl_reg_write_o;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk_i                     (clk_i),
        .rst_i                     (rst_i),
        .EXMEM_pc_branch_i         (EXMEM_pc_branch_i),
        .EXMEM_alu_i               (EXMEM_alu_i),
        .EXMEM_alu_do_branch_i     (EXMEM_alu_do_branch_i),
        .EXMEM_b_i                 (EXMEM_b_i),
        .EXMEM_reg_write_address_i (EXMEM_reg_write_address_i),
        .EXMEM_ctrl_branch_i       (EXMEM_ctrl_branch_i),
        .EXMEM_ctrl_mem_read_i     (EXMEM_ctrl_mem_read_i),
        .EXMEM_ctrl_mem_write_i    (EXMEM_ctrl_mem_write_i),
        .EXMEM_ctrl_reg_write_i    (EXMEM_ctrl_reg_write_i),
        .EXMEM_ctrl_mem_to_reg_i   (EXMEM_ctrl_mem_to_reg_i),
        .MEM_pc_src_o              (MEM_pc_src_o),
        .MEM_pc_branch_o           (MEM_pc_branch_o),
        .MEM_stall_o               (MEM_stall_o),
        .MEM_bus_err_o             (MEM_bus_err_o),
        .dmem_req_o                (dmem_req_o),
        .dmem_we_o                 (dmem_we_o),
        .dmem_addr_o               (dmem_addr_o),
        .dmem_be_o                 (dmem_be_o),
        .dmem_wdata_o              (dmem_wdata_o),
        .dmem_rdata_i              (dmem_rdata_i),
        .dmem_ack_i                (dmem_ack_i),
        .MEMWB_reg_write_data_o    (MEMWB_reg_write_data_o),
        .MEMWB_reg_write_address_o (MEMWB_reg_write_address_o),
        .MEMWB_ctrl_reg_write_o    (MEMWB_ctrl_reg_write_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
    } wb_t;

    typedef struct {
        logic [1:0]  rd_sz;
        logic [1:0]  wr_sz;
        logic [31:0] alu;
        logic [31:0] b;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        reg_wr;
        logic        m2r;
        int          ack_at;     // BUSY cycle that gets the ack, 0 = never
        logic        exp_req;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int          exp_stall;
        int          exp_req_n;
        int          exp_err;
        logic        exp_wb;
        logic [31:0] exp_wb_data;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl [NV];

    bus_t bus_q[$];
    wb_t  wb_q[$];
    bus_t held;
    logic req_prev = 1'b0;
    int   err_cnt  = 0;
    int   n_vec    = 0;
    int   n_miss   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic set_exmem(input logic [1:0] rsz, input logic [1:0] wsz, input logic [31:0] alu,
                             input logic [31:0] b, input logic [4:0] rd, input logic rw, input logic m2r);
        EXMEM_ctrl_mem_read_i     = rsz;
        EXMEM_ctrl_mem_write_i    = wsz;
        EXMEM_alu_i               = alu;
        EXMEM_b_i                 = b;
        EXMEM_reg_write_address_i = rd;
        EXMEM_ctrl_reg_write_i    = rw;
        EXMEM_ctrl_mem_to_reg_i   = m2r;
    endtask

    // Bus and writeback monitor, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (rst_i) begin
            req_prev = 1'b0;
        end else begin
            if (dmem_req_o && !req_prev) begin
                if (bus_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_req: got request addr %h, required none", dmem_addr_o);
                end else begin
                    held = bus_q.pop_front();
                    check("bus_we", 32'(dmem_we_o), 32'(held.we));
                    check("bus_addr", dmem_addr_o, held.addr);
                    check("bus_be", 32'(dmem_be_o), 32'(held.be));
                    if (held.we) check("bus_wdata", dmem_wdata_o, held.wdata);
                end
            end else if (dmem_req_o) begin
                check("bus_addr_hold", dmem_addr_o, held.addr);
            end
            req_prev = dmem_req_o;
            if (MEMWB_ctrl_reg_write_o) begin
                if (wb_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_wb: got data %h reg %0d, required no writeback",
                             MEMWB_reg_write_data_o, MEMWB_reg_write_address_o);
                end else begin
                    wb_t w;
                    w = wb_q.pop_front();
                    check("wb_data", MEMWB_reg_write_data_o, w.data);
                    check("wb_addr", 32'(MEMWB_reg_write_address_o), 32'(w.addr));
                end
            end
            if (MEM_bus_err_o) err_cnt++;
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic apply(input int idx);
        vec_t v;
        int   req_n;
        int   stall_n;
        int   err0;
        bit   retired;
        v       = tbl[idx];
        req_n   = 0;
        stall_n = 0;
        retired = 1'b0;
        err0    = err_cnt;
        set_exmem(v.rd_sz, v.wr_sz, v.alu, v.b, v.rd, v.reg_wr, v.m2r);
        dmem_rdata_i = v.rdata;
        if (v.exp_req) bus_q.push_back('{v.exp_we, v.exp_addr, v.exp_be, v.exp_wdata});
        if (v.exp_wb) wb_q.push_back('{v.exp_wb_data, v.rd});
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (dmem_req_o) begin
                req_n++;
                dmem_ack_i = (req_n == v.ack_at);
            end
            if (MEM_stall_o) stall_n++;
            else retired = 1'b1;
            @(posedge clk_i);
            #1;
            dmem_ack_i = 1'b0;
            if (retired) break;
        end
        set_exmem('0, '0, '0, '0, '0, 1'b0, 1'b0);
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        check($sformatf("v%0d_retired", idx), 32'(retired), 32'd1);
        check($sformatf("v%0d_stall_cycles", idx), 32'(stall_n), 32'(v.exp_stall));
        check($sformatf("v%0d_req_cycles", idx), 32'(req_n), 32'(v.exp_req_n));
        check($sformatf("v%0d_err_pulses", idx), 32'(err_cnt - err0), 32'(v.exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // rd_sz wr_sz alu b rdata rd reg_wr m2r ack_at | req we addr be wdata stall req_n err wb wb_data
        tbl[0]  = '{2'd0, 2'd0, 32'h12345678, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, 0,
                    1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 1'b1, 32'h12345678};
        tbl[1]  = '{2'd0, 2'd3, 32'h102, 32'h000000AB, 32'h0, 5'd0, 1'b0, 1'b0, 1,
                    1'b1, 1'b1, 32'h100, 4'b0100, 32'hABABABAB, 2, 1, 0, 1'b0, 32'h0};
        tbl[2]  = '{2'd2, 2'd0, 32'h202, 32'h0, 32'h8001FFFF, 5'd7, 1'b1, 1'b1, 3,
                    1'b1, 1'b0, 32'h200, 4'b1100, 32'h0, 4, 3, 0, 1'b1, 32'hFFFF8001};
        tbl[3]  = '{2'd1, 2'd0, 32'h301, 32'h0, 32'h0, 5'd3, 1'b1, 1'b1, 0,
                    1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 0, 1, 1'b0, 32'h0};
        tbl[4]  = '{2'd1, 2'd0, 32'h400, 32'h0, 32'h11111111, 5'd9, 1'b1, 1'b1, 0,
                    1'b1, 1'b0, 32'h400, 4'hF, 32'h0, 5, 4, 1, 1'b0, 32'h0};
        tbl[5]  = '{2'd0, 2'd0, 32'hCAFEF00D, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0, 0,
                    1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 1'b1, 32'hCAFEF00D};
        tbl[6]  = '{2'd3, 2'd0, 32'h503, 32'h0, 32'h7F000000, 5'd11, 1'b1, 1'b1, 2,
                    1'b1, 1'b0, 32'h500, 4'b1000, 32'h0, 3, 2, 0, 1'b1, 32'h0000007F};
        tbl[7]  = '{2'd3, 2'd0, 32'h601, 32'h0, 32'h00008000, 5'd12, 1'b1, 1'b1, 1,
                    1'b1, 1'b0, 32'h600, 4'b0010, 32'h0, 2, 1, 0, 1'b1, 32'hFFFFFF80};
        tbl[8]  = '{2'd1, 2'd0, 32'h700, 32'h0, 32'hDEADBEEF, 5'd13, 1'b1, 1'b1, 4,
                    1'b1, 1'b0, 32'h700, 4'hF, 32'h0, 5, 4, 0, 1'b1, 32'hDEADBEEF};
        tbl[9]  = '{2'd0, 2'd2, 32'h802, 32'h1234BEEF, 32'h0, 5'd0, 1'b0, 1'b0, 1,
                    1'b1, 1'b1, 32'h800, 4'b1100, 32'hBEEFBEEF, 2, 1, 0, 1'b0, 32'h0};
        tbl[10] = '{2'd1, 2'd1, 32'h904, 32'h55AA00FF, 32'hFFFFFFFF, 5'd14, 1'b0, 1'b0, 2,
                    1'b1, 1'b1, 32'h904, 4'hF, 32'h55AA00FF, 3, 2, 0, 1'b0, 32'h0};
        tbl[11] = '{2'd2, 2'd0, 32'hA01, 32'h0, 32'h0, 5'd15, 1'b1, 1'b1, 0,
                    1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 0, 1, 1'b0, 32'h0};
        tbl[12] = '{2'd1, 2'd0, 32'hB00, 32'h0, 32'h01020304, 5'd16, 1'b1, 1'b0, 1,
                    1'b1, 1'b0, 32'hB00, 4'hF, 32'h0, 2, 1, 0, 1'b1, 32'h00000B00};
        tbl[13] = '{2'd2, 2'd0, 32'hD00, 32'h0, 32'h12347ABC, 5'd17, 1'b1, 1'b1, 1,
                    1'b1, 1'b0, 32'hD00, 4'b0011, 32'h0, 2, 1, 0, 1'b1, 32'h00007ABC};

        rst_i                 = 1'b1;
        EXMEM_pc_branch_i     = '0;
        EXMEM_alu_do_branch_i = 1'b0;
        EXMEM_ctrl_branch_i   = 1'b0;
        dmem_rdata_i          = '0;
        dmem_ack_i            = 1'b0;
        set_exmem('0, '0, '0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_req", 32'(dmem_req_o), 32'd0);
        check("rst_bus", {dmem_addr_o[31:6], dmem_we_o, dmem_be_o, 1'b0} | dmem_wdata_o | 32'(dmem_addr_o[5:0]), 32'd0);
        check("rst_wb_data", MEMWB_reg_write_data_o, 32'd0);
        check("rst_wb_ctrl", {26'd0, MEMWB_reg_write_address_o, MEMWB_ctrl_reg_write_o}, 32'd0);
        check("rst_err", 32'(MEM_bus_err_o), 32'd0);
        rst_i = 1'b0;

        EXMEM_pc_branch_i = 32'h10000040;
        for (int k = 0; k < 4; k++) begin
            EXMEM_ctrl_branch_i   = k[1];
            EXMEM_alu_do_branch_i = k[0];
            #1;
            check("pc_src", 32'(MEM_pc_src_o), 32'(k == 3));
            check("pc_branch", MEM_pc_branch_o, 32'h10000040);
        end
        EXMEM_ctrl_branch_i   = 1'b0;
        EXMEM_alu_do_branch_i = 1'b0;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < NV; i++) apply(i);

        // Reset in the second BUSY cycle of a load, with a redirect held throughout.
        set_exmem(2'd1, 2'd0, 32'hC00, 32'h0, 5'd20, 1'b1, 1'b1);
        EXMEM_ctrl_branch_i   = 1'b1;
        EXMEM_alu_do_branch_i = 1'b1;
        EXMEM_pc_branch_i     = 32'h00004000;
        bus_q.push_back('{1'b0, 32'hC00, 4'hF, 32'h0});
        @(negedge clk_i);
        check("rb_idle_stall", 32'(MEM_stall_o), 32'd1);
        @(negedge clk_i);
        check("rb_busy1_req", 32'(dmem_req_o), 32'd1);
        check("rb_busy_pc_src", 32'(MEM_pc_src_o), 32'd1);
        check("rb_busy_pc_branch", MEM_pc_branch_o, 32'h00004000);
        @(negedge clk_i);
        check("rb_busy2_req", 32'(dmem_req_o), 32'd1);
        rst_i = 1'b1;
        set_exmem('0, '0, '0, '0, '0, 1'b0, 1'b0);
        EXMEM_ctrl_branch_i   = 1'b0;
        EXMEM_alu_do_branch_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("rb_req_dropped", 32'(dmem_req_o), 32'd0);
        check("rb_stall", 32'(MEM_stall_o), 32'd0);
        check("rb_wb_data", MEMWB_reg_write_data_o, 32'd0);
        check("rb_wb_ctrl", {26'd0, MEMWB_reg_write_address_o, MEMWB_ctrl_reg_write_o}, 32'd0);
        @(negedge clk_i);
        dmem_rdata_i = 32'hBAD0BAD0;
        dmem_ack_i   = 1'b1;
        @(posedge clk_i);
        #1;
        dmem_ack_i = 1'b0;
        @(negedge clk_i);
        check("late_ack_req", 32'(dmem_req_o), 32'd0);
        check("late_ack_stall", 32'(MEM_stall_o), 32'd0);
        check("late_ack_wb", 32'(MEMWB_ctrl_reg_write_o), 32'd0);
        check("late_ack_err", 32'(MEM_bus_err_o), 32'd0);
        @(posedge clk_i);
        #1;

        apply(0);
        apply(12);

        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
